// File: rtl/ysyx_24100029_fd_pkg.sv
// Shared types and helpers for the fetch-to-decode queue.
// Holds the slot record, the control-flow opcodes and the prefix counter.
package ysyx_24100029_fd_pkg;

  localparam int FD_ADDR_W = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0]          inst;
    logic [FD_ADDR_W-1:0] pc;
    logic                 is_ctrl;
  } fd_slot_t;

  // Number of consecutive ones starting at bit 0.
  function automatic logic [2:0] lead_ones4(input logic [3:0] v);
    logic [2:0] n;
    casez (v)
      4'b???0: n = 3'd0;
      4'b??01: n = 3'd1;
      4'b?011: n = 3'd2;
      4'b0111: n = 3'd3;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ysyx_24100029_predecode.sv
// Flags branches, jal and jalr so later stages know which slots redirect flow.
module ysyx_24100029_predecode
  import ysyx_24100029_fd_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_ctrl
);

  logic unused_hi;
  assign unused_hi = ^inst[31:7];

  assign is_ctrl = (inst[6:0] == OP_BRANCH) || (inst[6:0] == OP_JAL) ||
                   (inst[6:0] == OP_JALR);

endmodule

// File: rtl/ysyx_24100029_fd_queue.sv
// Four-slot compacting fetch-to-decode queue: drains a valid prefix into decode
// and refills from the IFU in the same cycle, keeping slots packed from slot 0.
module ysyx_24100029_fd_queue
  import ysyx_24100029_fd_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int Issue_Num  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr,
  input  logic [31:0]           inst_i   [Issue_Num],
  input  logic [ADDR_WIDTH-1:0] pc_i     [Issue_Num],
  input  logic [Issue_Num-1:0]  valid_i,
  output logic [Issue_Num-1:0]  ready_o,
  output logic [31:0]           inst_o   [Issue_Num],
  output logic [ADDR_WIDTH-1:0] pc_o     [Issue_Num],
  output logic [Issue_Num-1:0]  is_ctrl_o,
  output logic [Issue_Num-1:0]  valid_o,
  input  logic [Issue_Num-1:0]  dec_ready
);

  fd_slot_t       slot_q [Issue_Num];
  fd_slot_t       slot_d [Issue_Num];
  fd_slot_t       in_slot[Issue_Num];
  logic [Issue_Num-1:0] pre_ctrl;
  logic [2:0]     cnt_q, cnt_d;
  logic [2:0]     k, m, keep;
  logic [3:0]     free;
  logic [1:0]     src;

  for (genvar g = 0; g < Issue_Num; g++) begin : g_pre
    ysyx_24100029_predecode u_pre (
      .inst    (inst_i[g]),
      .is_ctrl (pre_ctrl[g])
    );
    assign in_slot[g] = '{inst: inst_i[g], pc: pc_i[g], is_ctrl: pre_ctrl[g]};
  end

  // Drain, free space and accept counts; dec_ready reaches ready_o combinationally.
  always_comb begin
    for (int j = 0; j < Issue_Num; j++) valid_o[j] = (cnt_q > 3'(j));
    k    = lead_ones4(dec_ready & valid_o);
    keep = cnt_q - k;
    free = 4'd4 - {1'b0, cnt_q} + {1'b0, k};
    for (int j = 0; j < Issue_Num; j++) ready_o[j] = !clr && (free > 4'(j));
    m     = lead_ones4(valid_i & ready_o);
    cnt_d = clr ? 3'd0 : keep + m;
  end

  // Survivors shift down by k; new entries land right behind them.
  always_comb begin
    src = 2'd0;
    for (int j = 0; j < Issue_Num; j++) begin
      slot_d[j] = slot_q[j];
      if (!clr) begin
        if (3'(j) < keep) begin
          src       = 2'(j) + k[1:0];
          slot_d[j] = slot_q[src];
        end else if (3'(j) < keep + m) begin
          src       = 2'(j) - keep[1:0];
          slot_d[j] = in_slot[src];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 3'd0;
      for (int j = 0; j < Issue_Num; j++) slot_q[j] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int j = 0; j < Issue_Num; j++) slot_q[j] <= slot_d[j];
    end
  end

  always_comb begin
    for (int j = 0; j < Issue_Num; j++) begin
      inst_o[j]    = slot_q[j].inst;
      pc_o[j]      = slot_q[j].pc;
      is_ctrl_o[j] = slot_q[j].is_ctrl;
    end
  end

  a_cnt_bound: assert property (@(posedge clock) disable iff (!reset) cnt_d <= 3'd4);

endmodule
